// File: rtl/adder_8bits_reg.sv
// Registered bank of independent 1-bit full adders. Each position has its own
// carry-in and carry-out; carries never ripple between positions.

module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

module adder_8bits_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] first_byte,
    input  logic [WIDTH-1:0] second_byte,
    input  logic [WIDTH-1:0] carry_in,
    output logic [WIDTH-1:0] sum_bytes,
    output logic [WIDTH-1:0] carry_out
);
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] c;

    // Position i sees only its own operands and carry-in.
    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        full_adder u_fa (
            .a   (first_byte[i]),
            .b   (second_byte[i]),
            .cin (carry_in[i]),
            .s   (s[i]),
            .cout(c[i])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_bytes <= '0;
            carry_out <= '0;
        end else begin
            sum_bytes <= s;
            carry_out <= c;
        end
    end
endmodule

// File: tb/tb_adder_8bits_reg.sv
// Bench for adder_8bits_reg: per-bit counting model plus directed vectors with
// hand-computed results.

module tb_adder_8bits_reg;
    logic       clk;
    logic       rst_n;
    logic [7:0] first_byte;
    logic [7:0] second_byte;
    logic [7:0] carry_in;
    logic [7:0] sum_bytes;
    logic [7:0] carry_out;

    int checks = 0;
    int errors = 0;
    logic chk_en = 1'b0;

    logic [7:0] exp_sum;
    logic [7:0] exp_cout;

    adder_8bits_reg #(.WIDTH(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .first_byte (first_byte),
        .second_byte(second_byte),
        .carry_in   (carry_in),
        .sum_bytes  (sum_bytes),
        .carry_out  (carry_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: count the ones at each position; low bit is the sum, >=2 is the carry.
    function automatic void model(input logic [7:0] a, input logic [7:0] b,
                                  input logic [7:0] ci,
                                  output logic [7:0] s, output logic [7:0] co);
        for (int i = 0; i < 8; i++) begin
            int n;
            n = int'(a[i]) + int'(b[i]) + int'(ci[i]);
            s[i]  = (n % 2) == 1;
            co[i] = n >= 2;
        end
    endfunction

    always @(posedge clk or negedge rst_n) begin
        logic [7:0] ms, mc;
        if (!rst_n) begin
            exp_sum  <= 8'h00;
            exp_cout <= 8'h00;
        end else begin
            model(first_byte, second_byte, carry_in, ms, mc);
            exp_sum  <= ms;
            exp_cout <= mc;
        end
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%02h, expected 0x%02h", name, act, req);
        end
    endtask

    // Continuous comparison against the model every cycle once out of power-up.
    always @(negedge clk) begin
        if (chk_en) begin
            check("model_sum", sum_bytes, exp_sum);
            check("model_cout", carry_out, exp_cout);
        end
    end

    task automatic apply(input string name, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] ci, input logic [7:0] es, input logic [7:0] ec);
        @(negedge clk);
        first_byte  = a;
        second_byte = b;
        carry_in    = ci;
        @(posedge clk);
        #1;
        check({name, "_sum"}, sum_bytes, es);
        check({name, "_cout"}, carry_out, ec);
    endtask

    initial begin
        logic [7:0] a, b, ci, ms, mc;
        rst_n       = 1'b0;
        first_byte  = 8'h00;
        second_byte = 8'h00;
        carry_in    = 8'h00;

        // Reset held with random inputs while clocking.
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            first_byte  = 8'($urandom);
            second_byte = 8'($urandom);
            carry_in    = 8'($urandom);
            @(posedge clk);
            #1;
            check("rst_hold_sum", sum_bytes, 8'h00);
            check("rst_hold_cout", carry_out, 8'h00);
        end
        chk_en = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;

        apply("zero", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        apply("v01", 8'h01, 8'h01, 8'h02, 8'h02, 8'h01);
        apply("v02", 8'h02, 8'h02, 8'h04, 8'h04, 8'h02);
        // Back-to-back: each apply drives one negedge after the previous check.
        apply("b2b0", 8'h0F, 8'h01, 8'h0F, 8'h01, 8'h0F);
        apply("b2b1", 8'hFF, 8'h01, 8'h40, 8'hBE, 8'h41);
        apply("allones", 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
        apply("no_ripple", 8'h01, 8'h01, 8'h00, 8'h00, 8'h01);

        // Every (a,b,cin) combination lands on every position, rotated per cycle.
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < 8; i++) begin
                int combo;
                combo = (i + k) % 8;
                a[i]  = combo[2];
                b[i]  = combo[1];
                ci[i] = combo[0];
            end
            model(a, b, ci, ms, mc);
            apply("exhaustive", a, b, ci, ms, mc);
        end

        // Reset asserted between edges clears outputs without waiting for clk.
        apply("pre_rst", 8'hAA, 8'h55, 8'hFF, 8'h00, 8'hFF);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_sum", sum_bytes, 8'h00);
        check("async_rst_cout", carry_out, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        apply("post_rst", 8'h0F, 8'hF0, 8'h00, 8'hFF, 8'h00);

        for (int k = 0; k < 20; k++) begin
            a  = 8'($urandom);
            b  = 8'($urandom);
            ci = 8'($urandom);
            model(a, b, ci, ms, mc);
            apply("random", a, b, ci, ms, mc);
        end

        @(negedge clk);
        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
